tile_judge: RTL
===============

# tile_judge

Parametrised chart sequencer and key judge for the piano-tiles game. It steps through a compile-time note chart across `LANES` lanes at a fixed step rate, decodes PS/2 make/break scancodes from the keyboard receiver, and judges each press against the open note. It maintains score, lives, hit/miss pulses and a game state for the VGA renderer and LED/HEX display logic.

## Interface
- `LANES`, 4: number of lanes, 1..5; lane codes are 1..LANES, 0 = EMPTY.
- `DEPTH`, 75: chart length in steps.
- `CHART`, all-EMPTY: `DEPTH*3`-bit chart; step 0 is in the MSBs.
- `STEP_TICKS`, 16667: clock cycles per step.
- `LIVES`, 3: misses allowed before a loss, 1..15.
- `SCORE_W`, 10: score width.
- `CLOCK_50` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: level; starts a game from IDLE.
- `received_data` in 8: PS/2 byte.
- `received_data_en` in 1: one-cycle strobe qualifying `received_data`.
- `expected` out 3: lane code of the open note (0 = EMPTY).
- `step_idx` out `$clog2(DEPTH)`: current step.
- `score` out `SCORE_W`: hit count, saturating.
- `lives` out 4: remaining lives.
- `hit`, `miss` out 1: one-cycle judgement pulses.
- `win`, `lose` out 1: levels, held until reset.
- `playing` out 1: high in PLAY.

## Operation
- States:
  - IDLE: `start` goes to PLAY.
  - PLAY: a chart end goes to WIN; `lives` reaching 0 goes to LOSE.
  - WIN and LOSE are absorbing; only `reset` leaves them.
- Entering PLAY:
  - `step_idx=0`, `expected=CHART[step 0]`.
  - Step timer cleared, note marked open.
- Scancode decode applies to every byte with `received_data_en`:
  - 0xF0 sets the break flag; the next byte is consumed silently and clears the flag.
  - 0xE0 is ignored and leaves the break flag unchanged.
  - Make codes map to lanes 1..5: A=0x1C, S=0x1B, D=0x23, F=0x2B, SPACE=0x29.
  - Lanes above `LANES` and unmapped codes map to lane 0.
- Judgement applies to make codes in PLAY only; bytes outside PLAY are decoded but never judged.
  - Lane equals `expected`, `expected≠0` and the note is open: `hit`, score+1 (saturating), note closed.
  - Otherwise (wrong lane, EMPTY step, already-closed note, unmapped key): `miss`.
- Step advance, on each step tick in PLAY:
  - An open non-EMPTY note is a `miss`.
  - Then `step_idx+1` and the next note is loaded and opened.
  - The tick after step `DEPTH-1` enters WIN instead of advancing.
- Each `miss` decrements `lives`. The decrement that reaches 0 enters LOSE on the same edge; LOSE wins over a simultaneous WIN.
- At most one `hit` or one `miss` is issued per cycle. A simultaneous key miss and expiry miss cost one life.

## Timing
- Reset values:
  - State IDLE, `expected=0`, `step_idx=0`, `score=0`, `lives=LIVES`.
  - `hit=miss=win=lose=playing=0`; break flag 0; step timer 0.
- Latency: a strobe at edge n gives `hit`/`miss`/`score`/`lives` at edge n+1.
- `start` sampled high in IDLE at edge n gives `playing=1` at edge n+1. The first step tick comes `STEP_TICKS` cycles after entering PLAY.
- Key strobe and step tick in the same cycle:
  - The key is judged against the old note.
  - A hit in that cycle suppresses the expiry miss, and the advance proceeds.
- `reset` mid-game returns every register to its reset value on the next edge; an in-flight break flag is discarded.
- Step timer: counts 0..`STEP_TICKS-1`, ticks on the terminal count, frozen outside PLAY.

## Configuration
- `TILE_JUDGE_COMBO_EN` defined:
  - Adds output `combo` (8 bits, saturating at 255, reset 0), cleared on every `miss`.
  - A hit with `combo≥8` before the increment adds 2 to score instead of 1, still saturating.
- Undefined: no `combo` port, every hit adds 1.

## Structure
- Package `tile_pkg` holds:
  - Scancode constants (lanes, 0xF0, 0xE0).
  - The `lane_t` 3-bit typedef with `LANE_EMPTY=0`.
  - The game-state enum `{IDLE, PLAY, WIN, LOSE}`.
  - A scancode-to-lane function.
- Sub-module `step_timer` (parameter `STEP_TICKS`; inputs clock, reset, enable; output one-cycle `tick`).
- Chart readout and judge FSM live in `tile_judge`.

## Test plan
- `STEP_TICKS=4`, chart {1,2,0,3}, `start` with no keys: misses at steps 0, 1 and 3; `lives` goes 3→2→1→0, then `lose=1`, and `win` is never set.
- Same chart, exact presses: 0x1C in step 0, 0x1B in step 1, 0x23 in step 3. Expect three hits, `score=3`, `lives=3`, and `win=1` one tick after step 3.
- Step 0 open (lane 1), bytes 0x1C, 0xF0, 0x1C, 0x1C: one hit, break byte swallowed, then one miss on the second make (note already closed).
- 0x1C strobe in the same cycle as the step-0 tick: `hit=1`, no expiry miss, `step_idx=1`.
- `reset` pulsed mid-PLAY with `score=2`: next edge gives IDLE, `score=0`, `lives=3`, `expected=0`.
- With `TILE_JUDGE_COMBO_EN`, 10 consecutive hits: `combo=10`, `score=1*8+2*2=12`; one miss clears `combo` to 0.

Source files
------------

// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared scancodes, lane type, game states and scancode-to-lane mapping
package tile_pkg;

  typedef logic [2:0] lane_t;
  localparam lane_t LANE_EMPTY = 3'd0;

  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} game_state_t;

  // Lanes beyond the configured lane count behave like unmapped keys.
  function automatic lane_t scan_to_lane(input logic [7:0] code, input int lanes);
    lane_t l;
    case (code)
      SC_A:     l = 3'd1;
      SC_S:     l = 3'd2;
      SC_D:     l = 3'd3;
      SC_F:     l = 3'd4;
      SC_SPACE: l = 3'd5;
      default:  l = LANE_EMPTY;
    endcase
    if (int'(l) > lanes) l = LANE_EMPTY;
    return l;
  endfunction

endpackage

// File: rtl/tile_judge_if.sv
// rtl/tile_judge_if.sv - PS/2 byte stream from the keyboard receiver
interface tile_judge_if;
  logic [7:0] received_data;
  logic       received_data_en;

  modport master (output received_data, output received_data_en);
  modport slave  (input  received_data, input  received_data_en);
endinterface

// File: rtl/tile_judge_step_timer.sv
// rtl/tile_judge_step_timer.sv - step timer, one-cycle tick on terminal count, frozen when disabled
module step_timer #(
  parameter int STEP_TICKS = 16667
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_TICKS - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset)       count <= '0;
    else if (enable) count <= (count == LAST) ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/tile_judge.sv
// rtl/tile_judge.sv - chart sequencer and key judge; TILE_JUDGE_COMBO_EN adds combo counter and bonus
module tile_judge
  import tile_pkg::*;
#(
  parameter int               LANES      = 4,
  parameter int               DEPTH      = 75,
  parameter logic [DEPTH*3-1:0] CHART    = '0,
  parameter int               STEP_TICKS = 16667,
  parameter int               LIVES      = 3,
  parameter int               SCORE_W    = 10
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  tile_judge_if.slave              kbd,
  output lane_t                    expected,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic [SCORE_W-1:0]       score,
  output logic [3:0]               lives,
  output logic                     hit,
  output logic                     miss,
  output logic                     win,
  output logic                     lose,
  output logic                     playing
`ifdef TILE_JUDGE_COMBO_EN
  ,
  output logic [7:0]               combo
`endif
);

  localparam int SW = $clog2(DEPTH);
  localparam logic [SW-1:0] LAST_STEP = SW'(DEPTH - 1);

  game_state_t state, state_nxt;
  lane_t expected_nxt, key_lane;
  logic [SW-1:0] step_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic [SCORE_W:0] score_sum;
  logic [3:0] lives_nxt;
  logic hit_nxt, miss_nxt, brk, brk_nxt, open, open_nxt;
  logic tick, make, key_hit, key_miss, exp_miss;
  logic [1:0] inc;
`ifdef TILE_JUDGE_COMBO_EN
  logic [7:0] combo_nxt;
`endif

  function automatic lane_t chart_at(input logic [SW-1:0] idx);
    return CHART[(DEPTH - 1 - int'(idx))*3 +: 3];
  endfunction

  step_timer #(.STEP_TICKS(STEP_TICKS)) u_timer (
    .clk(CLOCK_50), .reset(reset), .enable(state == PLAY), .tick(tick)
  );

  assign playing = (state == PLAY);
  assign win     = (state == WIN);
  assign lose    = (state == LOSE);

  always_comb begin
    state_nxt    = state;
    expected_nxt = expected;
    step_nxt     = step_idx;
    score_nxt    = score;
    lives_nxt    = lives;
    open_nxt     = open;
    brk_nxt      = brk;
    hit_nxt      = 1'b0;
    miss_nxt     = 1'b0;
    key_hit      = 1'b0;
    key_miss     = 1'b0;
    exp_miss     = 1'b0;
    inc          = 2'd1;
`ifdef TILE_JUDGE_COMBO_EN
    combo_nxt    = combo;
    if (combo >= 8'd8) inc = 2'd2;
`endif
    score_sum = {1'b0, score} + (SCORE_W+1)'(inc);

    // The byte after a break prefix is the released key and is never judged.
    key_lane = scan_to_lane(kbd.received_data, LANES);
    make = kbd.received_data_en && !brk &&
           (kbd.received_data != SC_BREAK) && (kbd.received_data != SC_EXT);
    if (kbd.received_data_en && kbd.received_data != SC_EXT)
      brk_nxt = brk ? 1'b0 : (kbd.received_data == SC_BREAK);

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = PLAY;
          step_nxt     = '0;
          expected_nxt = chart_at('0);
          open_nxt     = 1'b1;
        end
      end
      PLAY: begin
        key_hit  = make && open && (expected != LANE_EMPTY) && (key_lane == expected);
        key_miss = make && !key_hit;
        exp_miss = tick && open && (expected != LANE_EMPTY) && !key_hit;
        if (key_hit) begin
          hit_nxt   = 1'b1;
          open_nxt  = 1'b0;
          score_nxt = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
`ifdef TILE_JUDGE_COMBO_EN
          if (combo != 8'hFF) combo_nxt = combo + 8'd1;
`endif
        end
        if (tick) begin
          if (step_idx == LAST_STEP) begin
            state_nxt = WIN;
          end else begin
            step_nxt     = step_idx + 1'b1;
            expected_nxt = chart_at(step_idx + 1'b1);
            open_nxt     = 1'b1;
          end
        end
        // Key miss and expiry miss in one cycle cost a single life; losing overrides winning.
        if (key_miss || exp_miss) begin
          miss_nxt  = 1'b1;
          lives_nxt = lives - 4'd1;
`ifdef TILE_JUDGE_COMBO_EN
          combo_nxt = 8'd0;
`endif
          if (lives == 4'd1) state_nxt = LOSE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      expected <= LANE_EMPTY;
      step_idx <= '0;
      score    <= '0;
      lives    <= 4'(LIVES);
      hit      <= 1'b0;
      miss     <= 1'b0;
      brk      <= 1'b0;
      open     <= 1'b0;
`ifdef TILE_JUDGE_COMBO_EN
      combo    <= 8'd0;
`endif
    end else begin
      state    <= state_nxt;
      expected <= expected_nxt;
      step_idx <= step_nxt;
      score    <= score_nxt;
      lives    <= lives_nxt;
      hit      <= hit_nxt;
      miss     <= miss_nxt;
      brk      <= brk_nxt;
      open     <= open_nxt;
`ifdef TILE_JUDGE_COMBO_EN
      combo    <= combo_nxt;
`endif
    end
  end

endmodule
